// File: rtl/line_window_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_window_buffer_pkg
// Shared definitions for the line window buffer:
//   - default pixel width, line length and tap count
//   - sum-width helper (DW + clog2(NTAPS)), wide enough that the column sum
//     can never overflow
//   - tap-slice helper giving the LSB position of tap k in a packed tap column
// No ports (package).
// -----------------------------------------------------------------------------
package line_window_buffer_pkg;

   localparam int DEF_DW       = 32'sd8;
   localparam int DEF_LINE_LEN = 32'sd256;
   localparam int DEF_NTAPS    = 32'sd3;

   // Width of the unsigned column sum: NTAPS values of DW bits each.
   function automatic int lwb_sum_width(input int dw, input int ntaps);
      return dw + $clog2(ntaps);
   endfunction

   // LSB index of tap k (k = 0 is the current pixel, k lines above otherwise).
   function automatic int lwb_tap_lsb(input int k, input int dw);
      return k * dw;
   endfunction

endpackage

// File: rtl/line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
// Single-clock line storage: WIDTH x DEPTH words, one write port and one
// registered read port with independent addresses. Contents are not reset;
// only the read-data register is.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable (read data appears on the next clock)
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module line_ram #(
   parameter  int WIDTH = 32'sd16,
   parameter  int DEPTH = 32'sd256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage array write; deliberately not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; holds its value when no read is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end else begin
         r_rdata <= r_rdata;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/line_window_buffer.sv
// -----------------------------------------------------------------------------
// line_window_buffer
// Streaming raster line buffer. For every valid pixel it produces a vertical
// column of NTAPS taps (the pixel plus the co-located pixels of the NTAPS-1
// previous lines) two clocks later, once NTAPS-1 complete lines are held.
//
// Optional feature macro: LINE_WINDOW_SUM_EN
//   defined   -> out_sum carries the registered unsigned sum of all taps
//   undefined -> no adder, out_sum tied to zero (port list unchanged)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data carries a pixel this cycle
//   in_sof     in   start of frame (qualified by in_valid): line 0, col 0
//   in_data    in   pixel, DW bits
//   out_valid  out  out_* valid this cycle
//   out_col    out  column index of the tap column
//   out_taps   out  NTAPS*DW; slice k = pixel k lines above, slice 0 = current
//   out_sum    out  unsigned sum of all taps, DW+clog2(NTAPS) bits
// -----------------------------------------------------------------------------
module line_window_buffer
   import line_window_buffer_pkg::*;
#(
   parameter  int DW       = DEF_DW,
   parameter  int LINE_LEN = DEF_LINE_LEN,
   parameter  int NTAPS    = DEF_NTAPS,
   localparam int AW       = $clog2(LINE_LEN),
   localparam int SW       = lwb_sum_width(DW, NTAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [DW-1:0]       in_data,
   output logic                out_valid,
   output logic [AW-1:0]       out_col,
   output logic [NTAPS*DW-1:0] out_taps,
   output logic [SW-1:0]       out_sum
);

   // RAM word holds the NTAPS-1 previous lines of one column.
   localparam int RW  = (NTAPS - 32'sd1) * DW;
   // Row counter only needs to reach NTAPS-1.
   localparam int RBW = $clog2(NTAPS);

   localparam logic [AW-1:0]  COL_LAST = AW'(LINE_LEN - 32'sd1);
   localparam logic [RBW-1:0] ROW_FULL = RBW'(NTAPS - 32'sd1);

   // Column / row position counters.
   logic [AW-1:0]  r_col;
   logic [RBW-1:0] r_row;

   // Stage-1 state (pixel whose RAM read is in flight).
   logic           r_d1_valid;
   logic [DW-1:0]  r_d1_data;
   logic [AW-1:0]  r_d1_col;
   logic           r_d1_full;

   // Output registers.
   logic                r_out_valid;
   logic [AW-1:0]       r_out_col;
   logic [NTAPS*DW-1:0] r_out_taps;

   // Stage-1 combinational position.
   logic [AW-1:0]  w_col_cur;
   logic [RBW-1:0] w_row_cur;
   logic           w_full;
   logic           w_col_wrap;
   logic [AW-1:0]  w_col_nxt;
   logic [RBW-1:0] w_row_nxt;

   // Stage-2 data path.
   logic [RW-1:0]       w_ram_word;
   logic [NTAPS*DW-1:0] w_taps;

   // Current pixel position (sof forces a restart at line 0, col 0) and the
   // counter values for the following pixel; row saturates once full.
   always_comb begin
      w_col_cur  = r_col;
      w_row_cur  = r_row;
      w_col_nxt  = r_col;
      w_row_nxt  = r_row;
      if (in_sof) begin
         w_col_cur = '0;
         w_row_cur = '0;
      end else begin
         w_col_cur = r_col;
         w_row_cur = r_row;
      end
      w_full     = (w_row_cur == ROW_FULL);
      w_col_wrap = (w_col_cur == COL_LAST);
      if (w_col_wrap) begin
         w_col_nxt = '0;
         if (!w_full) begin
            w_row_nxt = w_row_cur + RBW'(1);
         end else begin
            w_row_nxt = w_row_cur;
         end
      end else begin
         w_col_nxt = w_col_cur + AW'(1);
         w_row_nxt = w_row_cur;
      end
   end

   // Position counters advance once per accepted pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (in_valid) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end else begin
         r_col <= r_col;
         r_row <= r_row;
      end
   end

   // Stage-1 registers: carry the pixel alongside its RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1_valid <= 1'b0;
         r_d1_data  <= '0;
         r_d1_col   <= '0;
         r_d1_full  <= 1'b0;
      end else begin
         r_d1_valid <= in_valid;
         if (in_valid) begin
            r_d1_data <= in_data;
            r_d1_col  <= w_col_cur;
            r_d1_full <= w_full;
         end else begin
            r_d1_data <= r_d1_data;
            r_d1_col  <= r_d1_col;
            r_d1_full <= r_d1_full;
         end
      end
   end

   // Full tap column; its low RW bits are also the write-back word, which
   // shifts every held line up by one slot and drops the oldest.
   assign w_taps = {w_ram_word, r_d1_data};

   // Read for stage 1 and write-back for stage 2 share a cycle but never the
   // same column: a column is revisited only LINE_LEN (>= 2) pixels later.
   line_ram #(
      .WIDTH (RW),
      .DEPTH (LINE_LEN)
   ) u_line_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (r_d1_valid),
      .i_waddr (r_d1_col),
      .i_wdata (w_taps[RW-1:0]),
      .i_re    (in_valid),
      .i_raddr (w_col_cur),
      .o_rdata (w_ram_word)
   );

   // Output stage: publish the column only for pixels that had full history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_col   <= '0;
         r_out_taps  <= '0;
      end else begin
         r_out_valid <= r_d1_valid & r_d1_full;
         if (r_d1_valid) begin
            r_out_col  <= r_d1_col;
            r_out_taps <= w_taps;
         end else begin
            r_out_col  <= r_out_col;
            r_out_taps <= r_out_taps;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_col   = r_out_col;
   assign out_taps  = r_out_taps;

`ifdef LINE_WINDOW_SUM_EN
   logic [SW-1:0] w_sum;
   logic [SW-1:0] r_out_sum;

   // Zero-extended unsigned sum of all taps; SW bits cannot overflow.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NTAPS; k++) begin
         w_sum = w_sum + SW'(w_taps[lwb_tap_lsb(k, DW) +: DW]);
      end
   end

   // Sum register, aligned with the tap output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_sum <= '0;
      end else if (r_d1_valid) begin
         r_out_sum <= w_sum;
      end else begin
         r_out_sum <= r_out_sum;
      end
   end

   assign out_sum = r_out_sum;
`else
   assign out_sum = '0;
`endif

endmodule
